// File: rtl/sad_min_select_if.sv
// sad_min_select_if
//   Batch-in / result-out bundle for the minimum-SAD selector.
//   master : batch source (drives start, sad_valid, sad_in; observes status and result)
//   slave  : the selector (receives batches; drives busy, done, best_sad, best_row_col)
//   Signals:
//     start        one-cycle pulse, begins a new window search
//     sad_valid    sad_in carries a valid batch this cycle
//     sad_in       NUM_CORES packed SADs, core k at [k*SAD_W +: SAD_W]
//     busy         search in progress
//     done         one-cycle pulse, window result is final
//     best_sad     running minimum SAD
//     best_row_col {row, col} of best_sad
interface sad_min_select_if #(
    parameter int NUM_CORES = 8,
    parameter int SAD_W     = 32,
    parameter int COORD_W   = 6
);
    logic                       start;
    logic                       sad_valid;
    logic [NUM_CORES*SAD_W-1:0] sad_in;
    logic                       busy;
    logic                       done;
    logic [SAD_W-1:0]           best_sad;
    logic [2*COORD_W-1:0]       best_row_col;

    modport master (
        output start, sad_valid, sad_in,
        input  busy, done, best_sad, best_row_col
    );

    modport slave (
        input  start, sad_valid, sad_in,
        output busy, done, best_sad, best_row_col
    );
endinterface

// File: rtl/sad_min_select.sv
// sad_min_select
//   Finds the minimum-SAD candidate position of one motion-estimation search
//   window. Each accepted batch holds NUM_CORES SADs for adjacent columns of
//   one search row; batches arrive in raster order. Each batch is reduced in
//   a two-stage compare pipeline and folded into a running best value and
//   {row, col} position, which feed the downstream min/row-col register.
//   Ports:
//     Clk  rising-edge clock
//     Rst  synchronous, active-high reset (aborts any search in progress)
//     bus  sad_min_select_if.slave: start, sad_valid, sad_in in;
//          busy, done, best_sad, best_row_col out
//   Ties resolve to the first minimum in raster order (strict less-than,
//   lower core index first within a batch). NUM_CORES must be a power of
//   two and at least 2.
module sad_min_select #(
    parameter int NUM_CORES = 8,
    parameter int SAD_W     = 32,
    parameter int COORD_W   = 6,
    parameter int WIN_ROWS  = 64,
    parameter int WIN_COLS  = 64
) (
    input  logic             Clk,
    input  logic             Rst,
    sad_min_select_if.slave  bus
);

    localparam logic [COORD_W-1:0] LAST_ROW  = COORD_W'(WIN_ROWS - 1);
    localparam logic [COORD_W-1:0] LAST_COLB = COORD_W'(WIN_COLS - NUM_CORES);
    localparam logic [COORD_W-1:0] COL_STEP  = COORD_W'(NUM_CORES);
    localparam logic [COORD_W-1:0] ROW_STEP  = COORD_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    typedef struct packed {
        logic [SAD_W-1:0]   sad;
        logic [COORD_W-1:0] col;
    } cand_t;

    // c0 comes from the lower half of the cores, c1 from the upper half.
    typedef struct packed {
        cand_t c1;
        cand_t c0;
    } pair_t;

    // a must be the lower-index (earlier) candidate: it wins ties.
    function automatic cand_t pick_lower(input cand_t a, input cand_t b);
        return (b.sad < a.sad) ? b : a;
    endfunction

    // Pairwise tree, in place: slot i takes the winner of slots 2i and 2i+1.
    // Adjacent pairing keeps index order, so ties keep the lowest core.
    function automatic pair_t reduce_to_two(
        input logic [NUM_CORES*SAD_W-1:0] sads,
        input logic [COORD_W-1:0]         base
    );
        cand_t c [NUM_CORES];
        pair_t r;
        for (int k = 0; k < NUM_CORES; k++) begin
            c[k].sad = sads[k*SAD_W +: SAD_W];
            c[k].col = base + COORD_W'(k);
        end
        for (int n = NUM_CORES; n > 2; n = n / 2) begin
            for (int i = 0; i < n / 2; i++) begin
                c[i] = pick_lower(c[2*i], c[2*i+1]);
            end
        end
        r.c0 = c[0];
        r.c1 = c[1];
        return r;
    endfunction

    state_t               state;
    logic                 busy_r;
    logic                 done_r;
    logic [COORD_W-1:0]   row_cnt;
    logic [COORD_W-1:0]   col_base;
    logic [SAD_W-1:0]     best_sad_r;
    logic [2*COORD_W-1:0] best_rc_r;

    logic                       vld_p0;
    logic [NUM_CORES*SAD_W-1:0] sad_p0;
    logic [COORD_W-1:0]         row_p0;
    logic [COORD_W-1:0]         colb_p0;

    logic                       vld_p1;
    pair_t                      pair_p1;
    logic [COORD_W-1:0]         row_p1;

    logic                       accept;
    cand_t                      s2_win;
    logic                       s2_update;

    assign accept = (state == ST_RUN) && bus.sad_valid;

    // ---- p0: accepted batch, tagged with its row and base column ----
    always_ff @(posedge Clk) begin
        if (accept) begin
            sad_p0  <= bus.sad_in;
            row_p0  <= row_cnt;
            colb_p0 <= col_base;
        end
    end

    // ---- p1: batch reduced to two candidates ----
    always_ff @(posedge Clk) begin
        if (vld_p0) begin
            pair_p1 <= reduce_to_two(sad_p0, colb_p0);
            row_p1  <= row_p0;
        end
    end

    // ---- p2: final pick against the running best ----
    always_comb begin
        s2_win    = pick_lower(pair_p1.c0, pair_p1.c1);
        s2_update = vld_p1 && (s2_win.sad < best_sad_r);
    end

    // Control FSM, batch counters, pipeline valids and running best.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state      <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            row_cnt    <= '0;
            col_base   <= '0;
            vld_p0     <= 1'b0;
            vld_p1     <= 1'b0;
            best_sad_r <= '1;
            best_rc_r  <= '0;
        end else begin
            vld_p0 <= accept;
            vld_p1 <= vld_p0;
            done_r <= 1'b0;

            if (s2_update) begin
                best_sad_r <= s2_win.sad;
                best_rc_r  <= {row_p1, s2_win.col};
            end

            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        state      <= ST_RUN;
                        busy_r     <= 1'b1;
                        row_cnt    <= '0;
                        col_base   <= '0;
                        best_sad_r <= '1;
                        best_rc_r  <= '0;
                    end
                end
                ST_RUN: begin
                    if (bus.sad_valid) begin
                        if (col_base == LAST_COLB) begin
                            col_base <= '0;
                            row_cnt  <= row_cnt + ROW_STEP;
                            if (row_cnt == LAST_ROW) begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            col_base <= col_base + COL_STEP;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!vld_p0 && !vld_p1) begin
                        state  <= ST_DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = busy_r;
    assign bus.done         = done_r;
    assign bus.best_sad     = best_sad_r;
    assign bus.best_row_col = best_rc_r;

endmodule

// File: tb/tb_sad_min_select.sv
// tb_sad_min_select
//   Bench for sad_min_select. Each window's expected {best_sad, best_row_col}
//   is computed by a raster-order first-minimum model while the batches are
//   driven and queued; the done monitor pops and compares it.
module tb_sad_min_select;

    localparam int NUM_CORES = 8;
    localparam int SAD_W     = 32;
    localparam int COORD_W   = 6;
    localparam int WIN_ROWS  = 64;
    localparam int WIN_COLS  = 64;
    localparam int NBATCH    = WIN_ROWS * WIN_COLS / NUM_CORES;
    localparam int BPR       = WIN_COLS / NUM_CORES;

    logic Clk;
    logic Rst;

    int n_cmp = 0;
    int n_mis = 0;
    int done_cnt = 0;
    logic [SAD_W+2*COORD_W-1:0] exp_q [$];

    sad_min_select_if #(
        .NUM_CORES(NUM_CORES),
        .SAD_W    (SAD_W),
        .COORD_W  (COORD_W)
    ) bus ();

    sad_min_select #(
        .NUM_CORES(NUM_CORES),
        .SAD_W    (SAD_W),
        .COORD_W  (COORD_W),
        .WIN_ROWS (WIN_ROWS),
        .WIN_COLS (WIN_COLS)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .bus(bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [SAD_W-1:0] sad_val(input int mode, input int row, input int colb, input int k);
        logic [SAD_W-1:0] v;
        case (mode)
            0: v = (row == 5 && colb == 16 && k == 3) ? 32'd7 : 32'(1000 + k);
            1: v = ((row == 0 && colb == 8) || (row == 10 && colb == 0)) ? 32'd50 : 32'd60;
            2: v = $urandom_range(5000, 200);
            3: v = (row == 0 && colb == 0) ? 32'(90 - 10 * k) : 32'd100;
            default: v = '1;
        endcase
        return v;
    endfunction

    always @(negedge Clk) begin
        logic [SAD_W+2*COORD_W-1:0] e;
        if (bus.done === 1'b1) begin
            done_cnt++;
            check_val("busy_low_with_done", 64'(bus.busy), 64'd0);
            if (exp_q.size() == 0) begin
                check_val("done_unexpected", 64'(bus.done), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check_val("best_sad", 64'(bus.best_sad), 64'(e[SAD_W+2*COORD_W-1:2*COORD_W]));
                check_val("best_row_col", 64'(bus.best_row_col), 64'(e[2*COORD_W-1:0]));
            end
        end
    end

    task automatic run_window(input int mode, input bit gaps, input bit abort);
        logic [SAD_W-1:0]     exp_sad;
        logic [2*COORD_W-1:0] exp_rc;
        logic [SAD_W-1:0]     v;
        int row, colb, n, done_before;
        exp_sad = '1;
        exp_rc  = '0;

        bus.start = 1'b1;
        @(negedge Clk);
        bus.start = 1'b0;
        check_val("busy_after_start", 64'(bus.busy), 64'd1);

        for (int b = 0; b < NBATCH; b++) begin
            row  = b / BPR;
            colb = (b % BPR) * NUM_CORES;
            if (gaps) begin
                // bubble with zero SADs and a stray start; both must be ignored
                bus.sad_valid = 1'b0;
                bus.sad_in    = '0;
                bus.start     = (b % 37 == 5);
                @(negedge Clk);
                bus.start = 1'b0;
            end
            for (int k = 0; k < NUM_CORES; k++) begin
                v = sad_val(mode, row, colb, k);
                bus.sad_in[k*SAD_W +: SAD_W] = v;
                if (v < exp_sad) begin
                    exp_sad = v;
                    exp_rc  = {row[COORD_W-1:0], COORD_W'(colb + k)};
                end
            end
            bus.sad_valid = 1'b1;
            @(negedge Clk);
            if (mode == 3 && b < 2) begin
                check_val("latency_hold", 64'(bus.best_sad), 64'hFFFF_FFFF);
            end
            if (mode == 3 && b == 2) begin
                check_val("latency_sad", 64'(bus.best_sad), 64'(exp_sad));
                check_val("latency_rc", 64'(bus.best_row_col), 64'(exp_rc));
            end
        end

        // extra batch of zeros and a start while draining: both ignored
        bus.sad_valid = 1'b1;
        bus.sad_in    = '0;
        bus.start     = 1'b1;
        if (!abort) exp_q.push_back({exp_sad, exp_rc});
        @(negedge Clk);
        bus.sad_valid = 1'b0;
        bus.start     = 1'b0;

        if (abort) begin
            @(negedge Clk);
            Rst = 1'b1;
            @(negedge Clk);
            Rst = 1'b0;
            check_val("abort_busy", 64'(bus.busy), 64'd0);
            check_val("abort_done", 64'(bus.done), 64'd0);
            check_val("abort_sad", 64'(bus.best_sad), 64'hFFFF_FFFF);
            check_val("abort_rc", 64'(bus.best_row_col), 64'd0);
            done_before = done_cnt;
            repeat (8) @(negedge Clk);
            check_val("no_done_after_abort", 64'(done_cnt), 64'(done_before));
        end else begin
            n = 1;
            while (bus.done !== 1'b1 && n < 20) begin
                @(negedge Clk);
                n++;
            end
            check_val("done_latency", 64'(n), 64'd3);
            bus.start = 1'b1;
            @(negedge Clk);
            bus.start = 1'b0;
            check_val("start_in_done_ignored", 64'(bus.busy), 64'd0);
            check_val("done_one_cycle", 64'(bus.done), 64'd0);
        end
    endtask

    initial begin
        Rst           = 1'b1;
        bus.start     = 1'b0;
        bus.sad_valid = 1'b0;
        bus.sad_in    = '0;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        check_val("reset_busy", 64'(bus.busy), 64'd0);
        check_val("reset_done", 64'(bus.done), 64'd0);
        check_val("reset_sad", 64'(bus.best_sad), 64'hFFFF_FFFF);
        check_val("reset_rc", 64'(bus.best_row_col), 64'd0);

        bus.sad_valid = 1'b1;
        repeat (2) @(negedge Clk);
        bus.sad_valid = 1'b0;
        check_val("idle_ignores_valid", 64'(bus.best_sad), 64'hFFFF_FFFF);
        check_val("idle_stays_idle", 64'(bus.busy), 64'd0);

        run_window(0, 1'b0, 1'b0);
        run_window(1, 1'b0, 1'b0);
        run_window(2, 1'b1, 1'b0);
        run_window(3, 1'b0, 1'b0);
        run_window(0, 1'b0, 1'b1);
        run_window(1, 1'b0, 1'b0);
        run_window(4, 1'b0, 1'b0);

        repeat (4) @(negedge Clk);
        check_val("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/sad_min_select.md
Name: sad_min_select

Overview:
- Selects the minimum-SAD candidate position for one motion-estimation search window.
- Each cycle it accepts one batch of eight SAD values, one per processor core, covering eight adjacent columns of one search row.
- It reduces each batch in a two-stage compare pipeline and keeps a running best value and position.
- It drives the min/row-col holding register directly downstream (best_sad to min_in, best_row_col to row_col_in) and signals completion when the whole window has been searched.

Parameters:
- NUM_CORES, 8, SAD values per batch; must be a power of two.
- SAD_W, 32, width of each SAD value.
- COORD_W, 6, width of the row and column fields; row_col = {row, col}.
- WIN_ROWS, 64, search rows per window; must be ≤ 2^COORD_W.
- WIN_COLS, 64, search columns per window; must be a multiple of NUM_CORES and ≤ 2^COORD_W.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a new window search.
- sad_valid  in  1  sad_in carries a valid batch this cycle.
- sad_in  in  NUM_CORES*SAD_W  packed SADs; core k occupies bits [k*SAD_W +: SAD_W].
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the window result is final.
- best_sad  out  SAD_W  running minimum SAD.
- best_row_col  out  2*COORD_W  {row, col} of best_sad.

Behaviour:
- Reset: state IDLE; busy=0; done=0; best_sad all-ones; best_row_col=0; batch counters=0; pipeline valids=0. Rst mid-search aborts immediately; no done is produced for the aborted window.
- States:
  - IDLE: start → RUN, with best_sad←all-ones, best_row_col←0, row_cnt=0, col_base=0. sad_valid is ignored in IDLE and DONE.
  - RUN: busy=1. On each sad_valid cycle the batch is tagged with (row_cnt, col_base).
    - col_base advances by NUM_CORES.
    - At WIN_COLS-NUM_CORES, col_base wraps to 0 and row_cnt increments.
    - Acceptance of batch number (WIN_ROWS*WIN_COLS/NUM_CORES) → DRAIN. Further sad_valid is ignored.
  - DRAIN: waits until both pipeline stages are empty → DONE.
  - DONE: done=1 for exactly one cycle, busy=0 → IDLE. best_sad and best_row_col hold until the next start.
- start while busy is ignored. start in the DONE cycle is also ignored.
- Pipeline:
  - S1 (registered): reduce NUM_CORES candidates to 2 via a combinational compare tree. Each candidate carries its value and its column (col_base + k).
  - S2 (registered): reduce 2 to 1, then compare with the current best. Update when the candidate is strictly less.
  - A batch accepted at edge t affects best_sad/best_row_col after edge t+2.
  - Gaps in sad_valid are allowed; bubbles propagate without updating.
- Tie-break: always strict less-than. On equal values the lower core index wins within a batch, and the earlier batch wins across batches. The result is therefore the first minimum in raster order.
- Arithmetic: comparisons are unsigned SAD_W bits. An all-ones SAD never replaces the initial best; best_row_col then stays 0.
- Reset during DRAIN discards the in-flight batches.

Test Plan:
- Window search with core k of every batch = 1000+k, except batch (row 5, cols 16..23) where core 3 = 7 → done pulse; best_sad=7; best_row_col={6'd5,6'd19}; busy low the same cycle done is high.
- Batch with all eight SADs = 50, every other batch = 60 at row 0, col_base 8 → best_row_col={0,8}. Same value 50 repeated at a later row → unchanged (first minimum kept).
- sad_valid toggled every other cycle with start pulses injected mid-search → start ignored. done occurs exactly one cycle after the drain that follows the 512th accepted batch. Total accepted batches = 512.
- Single batch [90,80,70,60,50,40,30,20] at (0,0) → best_sad=20 and best_row_col={0,7}, visible two edges after acceptance.
- Rst asserted three cycles into DRAIN → next edge: busy=0, done never pulses, best_sad=32'hFFFFFFFF, best_row_col=0. A following start runs a clean search.
- All SADs = 32'hFFFFFFFF → done asserted; best_sad=32'hFFFFFFFF; best_row_col=0.
